// File: rtl/reverb_pkg.sv
// Purpose: shared types, constants and helpers for the reverb tap scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reverb_pkg;

  // Scheduler sequence: memory clear, wait for a sample, tap reads, write-back, output.
  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  localparam int GAIN_BITS  = 8;  // unsigned Q0.8 tap gain
  localparam int GAIN_SHIFT = 8;  // drops the Q0.8 fraction from the tap sum

  // Accumulator width: one signed x unsigned product plus growth for NUM_TAPS additions.
  function automatic int acc_bits(input int data_bits, input int num_taps);
    return data_bits + GAIN_BITS + $clog2(num_taps);
  endfunction

  // Saturation test against a signed range of 'bits' bits.
  // Returns {above_max, below_min}; the caller substitutes the clamp value.
  function automatic logic [1:0] sat_code(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return {(v > hi), (v < lo)};
  endfunction

endpackage

// File: rtl/reverb_tap_mac.sv
// Purpose: registered signed sample x unsigned gain multiply-accumulate with clear/enable.
// Latency: product lands in acc one cycle after en; clr zeroes acc on the next edge.
// Backpressure: none; en qualifies every operand pair.
// Ports: clk/rst_n, clr (priority over en), en, sample (signed), gain (unsigned), acc (signed sum).
module reverb_tap_mac
  import reverb_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int ACC_BITS  = 26
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [DATA_BITS-1:0] sample,
  input  logic        [GAIN_BITS-1:0] gain,
  output logic signed [ACC_BITS-1:0]  acc
);

  localparam int PROD_BITS = DATA_BITS + GAIN_BITS + 1;

  logic signed [PROD_BITS-1:0] prod;

  // Gain gets a zero sign bit so the multiply stays signed x unsigned.
  assign prod = PROD_BITS'(sample) * $signed({{(DATA_BITS + 1){1'b0}}, gain});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_BITS'(prod);
    end
  end

endmodule

// File: rtl/reverb_tap_scheduler.sv
// Purpose: sequences one shared delay RAM: post-reset clear, NUM_TAPS tap reads, write-back, mix.
// Latency: sample_valid -> dout_valid is NUM_TAPS+3 cycles; RAM clear takes 2**ADDR_BITS cycles.
// Backpressure: busy high while clearing or processing; samples arriving then are dropped with overrun.
// Ports: sample_valid/din in; tap_delay/tap_gain config (latched per sample);
//        mem_addr/mem_we/mem_wdata/mem_rdata to an external 1-cycle RAM; dout/dout_valid, busy, overrun out.
module reverb_tap_scheduler
  import reverb_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 10,
  parameter int NUM_TAPS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sample_valid,
  input  logic signed [DATA_BITS-1:0]     din,
  input  logic [NUM_TAPS*ADDR_BITS-1:0]   tap_delay,
  input  logic [NUM_TAPS*GAIN_BITS-1:0]   tap_gain,
  output logic [ADDR_BITS-1:0]            mem_addr,
  output logic                            mem_we,
  output logic [DATA_BITS-1:0]            mem_wdata,
  input  logic signed [DATA_BITS-1:0]     mem_rdata,
  output logic signed [DATA_BITS-1:0]     dout,
  output logic                            dout_valid,
  output logic                            busy,
  output logic                            overrun
);

  localparam int ACC_BITS = acc_bits(DATA_BITS, NUM_TAPS);
  localparam int KW       = $clog2(NUM_TAPS + 1);
  localparam logic [KW-1:0]        K_LAST    = KW'(NUM_TAPS - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;
  localparam logic signed [DATA_BITS-1:0] DMAX = {1'b0, {(DATA_BITS - 1){1'b1}}};
  localparam logic signed [DATA_BITS-1:0] DMIN = {1'b1, {(DATA_BITS - 1){1'b0}}};

  state_t state, state_nx;

  logic [ADDR_BITS-1:0]          wr_ptr;
  logic [ADDR_BITS-1:0]          clr_cnt;
  logic [KW-1:0]                 k;
  logic [KW-1:0]                 rd_k;
  logic                          rd_vld;
  logic                          rd_dis;
  logic signed [DATA_BITS-1:0]   din_q;
  logic [NUM_TAPS*ADDR_BITS-1:0] delay_q;
  logic [NUM_TAPS*GAIN_BITS-1:0] gain_q;
  logic                          accept;
  logic [ADDR_BITS-1:0]          cur_delay;
  logic [GAIN_BITS-1:0]          mac_gain;
  logic signed [ACC_BITS-1:0]    acc;
  logic signed [ACC_BITS:0]      sum;
  logic [1:0]                    sat;
  logic signed [DATA_BITS-1:0]   sat_d;

  assign accept    = (state == IDLE) && sample_valid;
  assign cur_delay = delay_q[k*ADDR_BITS +: ADDR_BITS];

  // rd_k/rd_dis trail the address by one cycle so the gain lines up with mem_rdata.
  // A disabled tap still spends its cycle but feeds a zero gain.
  assign mac_gain = rd_dis ? '0 : gain_q[rd_k*GAIN_BITS +: GAIN_BITS];

  // Dry sample plus wet taps with the Q0.8 fraction dropped (floor via arithmetic shift).
  assign sum   = (ACC_BITS + 1)'(din_q) + (ACC_BITS + 1)'(acc >>> GAIN_SHIFT);
  assign sat   = sat_code(64'(sum), DATA_BITS);
  assign sat_d = sat[1] ? DMAX : (sat[0] ? DMIN : sum[DATA_BITS-1:0]);

  reverb_tap_mac #(
    .DATA_BITS(DATA_BITS),
    .ACC_BITS (ACC_BITS)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (rd_vld),
    .sample(mem_rdata),
    .gain  (mac_gain),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b1;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
        if (clr_cnt == ADDR_LAST) state_nx = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        if (sample_valid) state_nx = RD;
      end
      RD: begin
        // Modular subtraction wraps naturally at the RAM depth.
        mem_addr = wr_ptr - cur_delay;
        if (k == K_LAST) state_nx = WR;
      end
      WR: begin
        mem_addr  = wr_ptr;
        mem_we    = 1'b1;
        mem_wdata = din_q;
        state_nx  = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      clr_cnt    <= '0;
      k          <= '0;
      rd_k       <= '0;
      rd_vld     <= 1'b0;
      rd_dis     <= 1'b0;
      din_q      <= '0;
      delay_q    <= '0;
      gain_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun    <= sample_valid && busy;
      dout_valid <= (state == DONE);
      rd_vld     <= (state == RD);
      rd_k       <= k;
      rd_dis     <= (cur_delay == '0);
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      // Config is sampled only here, so mid-sequence changes wait for the next sample.
      if (accept) begin
        din_q   <= din;
        delay_q <= tap_delay;
        gain_q  <= tap_gain;
        k       <= '0;
      end else if (state == RD) begin
        k <= k + 1'b1;
      end
      if (state == WR) wr_ptr <= wr_ptr + 1'b1;
      if (state == DONE) dout <= sat_d;
    end
  end

endmodule

// File: tb/tb_reverb_tap_scheduler.sv
// Purpose: randomized scoreboard bench for reverb_tap_scheduler against a sample-history model.
// Latency: expects dout_valid NUM_TAPS+3 cycles after an accepted sample, write-back at +5.
// Backpressure: models busy windows; samples offered while busy must raise overrun next cycle.
module tb_reverb_tap_scheduler;

  localparam int DB = 16;
  localparam int AB = 4;
  localparam int NT = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   sample_valid = 1'b0;
  logic signed [DB-1:0]   din = '0;
  logic [NT*AB-1:0]       tap_delay = '0;
  logic [NT*8-1:0]        tap_gain = '0;
  logic [AB-1:0]          mem_addr;
  logic                   mem_we;
  logic [DB-1:0]          mem_wdata;
  logic signed [DB-1:0]   mem_rdata = '0;
  logic signed [DB-1:0]   dout;
  logic                   dout_valid;
  logic                   busy;
  logic                   overrun;

  reverb_tap_scheduler #(.DATA_BITS(DB), .ADDR_BITS(AB), .NUM_TAPS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .din(din),
    .tap_delay(tap_delay), .tap_gain(tap_gain), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM, one-cycle read latency.
  logic signed [DB-1:0] ram [1<<AB];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int due; } res_t;
  typedef struct { int addr; int data; int due; } wr_t;

  res_t dq[$];
  wr_t  wq[$];
  int   oq[$];
  int   hist[$];     // every sample written since the last clear, oldest first
  int   wp_m = 0;    // model write pointer
  int   free_cycle = 0;
  int   busy_from = 0;
  int   busy_until = 0;
  bit   chk_en = 1'b0;
  int   passed = 0;
  int   total = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // Reference: output = din + floor(sum of delayed*gain / 256), clamped to 16-bit signed.
  function automatic int model(input int d, input logic [NT*AB-1:0] dl, input logic [NT*8-1:0] gn);
    longint acc = 0;
    longint s;
    for (int t = 0; t < NT; t++) begin
      int dk = int'(dl[t*AB +: AB]);
      int g  = int'(gn[t*8 +: 8]);
      if (dk != 0 && hist.size() >= dk) acc += longint'(hist[hist.size() - dk]) * g;
    end
    s = longint'(d) + (acc >>> 8);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic send(input int d, input logic [NT*AB-1:0] dl, input logic [NT*8-1:0] gn);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    din = DB'(d);
    tap_delay = dl;
    tap_gain = gn;
    if (cyc >= free_cycle) begin
      dq.push_back('{val: model(d, dl, gn), due: cyc + NT + 3});
      wq.push_back('{addr: wp_m, data: d, due: cyc + NT + 1});
      wp_m = (wp_m + 1) % (1 << AB);
      hist.push_back(d);
      free_cycle = cyc + NT + 3;
      busy_from = cyc + 1;
      busy_until = cyc + NT + 3;
    end else begin
      oq.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    // Scramble inputs so any config not latched at acceptance shows up as a wrong result.
    sample_valid = 1'b0;
    din = DB'($urandom);
    tap_delay = (NT*AB)'($urandom);
    tap_gain = $urandom;
  endtask

  task automatic wait_free();
    while (cyc + 1 < free_cycle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    int r;
    @(posedge clk); #1;
    chk_en = 1'b0;
    sample_valid = 1'b0;
    rst_n = 1'b0;
    dq.delete(); wq.delete(); oq.delete(); hist.delete();
    wp_m = 0;
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_mem_addr", int'(mem_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    free_cycle = r + (1 << AB);
    for (int i = 0; i < (1 << AB); i++) begin
      @(negedge clk);
      check("clr_we", int'(mem_we), 1);
      check("clr_addr", int'(mem_addr), i);
      check("clr_wdata", int'(mem_wdata), 0);
      check("clr_busy", int'(busy), 1);
      // One sample offered mid-clear must be dropped.
      if (i == 4) begin
        sample_valid = 1'b1;
        din = 16'sd777;
        oq.push_back(cyc + 1);
      end
      if (i == 5) sample_valid = 1'b0;
    end
    @(negedge clk);
    check("clr_done_busy", int'(busy), 0);
    check("clr_done_we", int'(mem_we), 0);
    busy_from = 0;
    busy_until = 0;
    chk_en = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) begin
        if (dq.size() == 0) check("dout_unexpected", 1, 0);
        else begin
          check("dout_value", int'(dout), dq[0].val);
          check("dout_cycle", cyc, dq[0].due);
          void'(dq.pop_front());
        end
      end else if (dq.size() != 0 && dq[0].due < cyc) begin
        check("dout_missing", 0, 1);
        void'(dq.pop_front());
      end
      if (oq.size() != 0 && oq[0] <= cyc) begin
        check("overrun", int'(overrun), 1);
        void'(oq.pop_front());
      end else if (overrun) begin
        check("overrun_spurious", 1, 0);
      end
      if (chk_en) begin
        check("busy", int'(busy), int'(cyc >= busy_from && cyc < busy_until));
        if (mem_we) begin
          if (wq.size() == 0 || wq[0].due != cyc) check("write_unexpected", 1, 0);
          else begin
            check("write_addr", int'(mem_addr), wq[0].addr);
            check("write_data", int'($signed(mem_wdata)), wq[0].data);
            void'(wq.pop_front());
          end
        end else if (wq.size() != 0 && wq[0].due <= cyc) begin
          check("write_missing", 0, 1);
          void'(wq.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();

    // Dry path, then a single half-gain tap; disabled taps carry nonzero gains.
    send(1000, 16'h0000, 32'hFFFFFFFF);
    wait_free(); send(1000, 16'h0001, 32'hFFFFFF80);
    wait_free(); send(0, 16'h0001, 32'hFFFFFF80);
    wait_free(); send(0, 16'h0001, 32'hFFFFFF80);

    // Saturation both ways.
    wait_free(); send(32000, 16'h0000, 32'h00000000);
    wait_free(); send(32000, 16'h1111, 32'hFFFFFFFF);
    wait_free(); send(-32000, 16'h0000, 32'h00000000);
    wait_free(); send(-32000, 16'h1111, 32'hFFFFFFFF);

    // Sample offered in cycle 3 of an active sequence.
    wait_free(); send(1200, 16'h0021, 32'h40408080);
    @(posedge clk); #1;
    send(-555, 16'h0000, 32'h0);

    // Random traffic with random gaps; some land while busy.
    for (int i = 0; i < 60; i++) begin
      int gap = $urandom_range(0, 8);
      repeat (gap) begin @(posedge clk); #1; end
      send($urandom_range(0, 65535) - 32768, (NT*AB)'($urandom), $urandom);
    end

    // Long tap across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      wait_free();
      send($urandom_range(0, 40000) - 20000, 16'h000F, 32'hFFFFFFFF);
    end

    // Reset during a tap read: result discarded, clear reruns.
    wait_free(); send(1234, 16'h1111, 32'hFFFFFFFF);
    do_reset();
    wait_free(); send(500, 16'h0001, 32'h00000080);
    wait_free(); send(500, 16'h0001, 32'h00000080);

    repeat (30) @(posedge clk);
    #1;
    check("drain", dq.size() + wq.size() + oq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reverb_tap_scheduler.md
Name: reverb_tap_scheduler

Overview:
- Sequences a single shared synchronous delay-line RAM for a multi-tap reverb. Per accepted audio sample it reads NUM_TAPS delayed samples, accumulates gain-weighted taps, writes the new sample and emits the mixed output.
- Sits between the sample-rate source (codec/I2S receive strobe) and the output stage.
- Owns the RAM write pointer and the post-reset memory clear.

Parameters:
DATA_BITS, 16, signed audio sample width
ADDR_BITS, 10, delay RAM address width; depth = 2**ADDR_BITS
NUM_TAPS, 4, taps read per sample (1..8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe, din valid
din  in  DATA_BITS  signed input sample
tap_delay  in  NUM_TAPS*ADDR_BITS  per-tap delay in samples, tap k at bits [k*ADDR_BITS +: ADDR_BITS]; 0 = tap disabled
tap_gain  in  NUM_TAPS*8  per-tap unsigned gain, Q0.8 (255 ≈ 0.996)
mem_addr  out  ADDR_BITS  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_BITS  RAM write data
mem_rdata  in  DATA_BITS  RAM read data, valid one cycle after address
dout  out  DATA_BITS  signed mixed output
dout_valid  out  1  one-cycle strobe, dout valid
busy  out  1  high when a sample cannot be accepted
overrun  out  1  one-cycle pulse when sample_valid is dropped

Behaviour:
- Reset (async assert, sync release): state CLEAR, wr_ptr=0, clr_cnt=0, dout=0, dout_valid=0, overrun=0, accumulator=0.
- FSM states: CLEAR, IDLE, RD, WR, DONE.
- CLEAR:
  - mem_we=1, mem_wdata=0, mem_addr=clr_cnt; clr_cnt increments each cycle.
  - After address 2**ADDR_BITS-1 is written, go to IDLE. Duration is exactly 2**ADDR_BITS cycles; busy=1 throughout.
- IDLE: busy=0, mem_we=0. On sample_valid:
  - latch din, tap_delay and tap_gain (config changes take effect only at a sample boundary);
  - clear accumulator, k=0, go to RD.
- Cycle numbering: acceptance cycle = 0.
  - Cycles 1..N (RD): mem_addr = wr_ptr - tap_delay[k] (mod 2**ADDR_BITS), k increments.
  - Cycles 2..N+1: accumulator += mem_rdata * gain[k-1] as signed×unsigned, full width DATA_BITS+8+clog2(NUM_TAPS).
  - Disabled tap (delay 0): still occupies its cycle, contributes 0 (no self-read of the unwritten slot).
- Cycle N+1 (WR): mem_addr=wr_ptr, mem_we=1, mem_wdata=latched din. wr_ptr increments at the end of the cycle, wrapping 2**ADDR_BITS-1 -> 0.
- Cycle N+2 (DONE):
  - sum = din + (acc >>> 8) (arithmetic shift), saturated to the signed DATA_BITS range;
  - registered into dout; return to IDLE.
- dout_valid=1 in cycle N+3 only; dout holds its value until the next result.
- Latency sample_valid -> dout_valid = N+3 cycles. busy=1 in cycles 1..N+2. The next sample can be accepted in cycle N+3.
- sample_valid while busy (including CLEAR): sample dropped, overrun=1 the following cycle, no state change.
- Outside CLEAR and WR, mem_we=0 and mem_wdata=0.
- A tap with delay d reads the sample written d samples earlier. Max delay 2**ADDR_BITS-1.
- rst_n asserted mid-sequence: immediate return to reset values; CLEAR reruns; any in-flight sample is lost, no dout_valid.

Decomposition:
- Package reverb_pkg:
  - state enum (CLEAR, IDLE, RD, WR, DONE);
  - GAIN_BITS=8, GAIN_SHIFT=8;
  - ACC_BITS function of DATA_BITS/NUM_TAPS;
  - saturation function.
- Sub-module reverb_tap_mac: registered signed×unsigned multiply-accumulate with clear and enable; the scheduler instantiates one.
- The RAM is external; simple_reverb-style inline arrays are not used.

Test Plan (ADDR_BITS=4, NUM_TAPS=4, behavioural 1-cycle-latency RAM model):
- Reset release -> exactly 16 consecutive mem_we cycles with mem_wdata=0 at addresses 0..15, busy=1 throughout, busy=0 in cycle 17.
- All gains 0, din=1000 -> dout_valid 7 cycles after sample_valid, dout=1000; write at address 0, then next sample writes address 1.
- tap0 delay=1 gain=128, others disabled; samples 1000 then 0 -> second dout = 0 + (1000*128>>8) = 500; third dout = 0.
- Saturation: din=32000, four taps delay=1 gain=255 on a previous sample of 32000 -> dout=32767; with negatives (-32000) -> dout=-32768.
- sample_valid asserted in cycle 3 of an active sequence -> overrun pulse in cycle 4, no extra dout_valid, in-flight result unaffected.
- Wrap: 17 samples with tap0 delay=15 -> mem_addr wraps 15->0, and the tap reads the sample written 15 samples earlier. rst_n pulsed in an RD cycle -> outputs zero immediately, CLEAR restarts, no dout_valid.
